uart_tx: RTL and testbench

UART transmit path: accepts a parallel byte from the system side with a valid/busy handshake and serializes it onto `TX_OUT` as one frame: start bit, data bits LSB first, an optional parity bit, and a stop bit. It runs on the TX bit clock, one `CLK` cycle per bit. It is the transmit counterpart of the oversampling receive chain in the same UART interface.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_serializer.sv | 43 ++++
 rtl/uart_tx.sv | 85 ++++++++
 tb/tb_uart_tx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// parity selection and serial line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // data_xor is the XOR reduction of the data word
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        logic p;
        p = data_xor;
        case (par_typ)
            PAR_EVEN: p = data_xor;
            PAR_ODD:  p = ~data_xor;
            default:  p = data_xor;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register with bit counter; ser_bit is the data bit to put on
// the line in the next cycle, done flags the last data bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8   // must be at least 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ser_bit,
    output logic                  done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;

    // NOTE: the shift register is ordinary state, not a memory array, so it
    // takes the asynchronous reset like every other flop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= data;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= shift_q >> 1;
            cnt_q   <= done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // While shifting, the output register is loaded with the bit about to
    // move into position 0, keeping TX_OUT aligned with the counter.
    assign ser_bit = shift_en ? shift_q[1] : shift_q[0];
    assign done    = (cnt_q == LAST_IDX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit,
// one CLK cycle per bit, with registered TX_OUT and Busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      par_en_q, par_bit_q;
    logic      load, shift_en, ser_bit, ser_done;

    assign load     = (state_q == IDLE) && Data_Valid;
    assign shift_en = (state_q == DATA);

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .shift_en (shift_en),
        .data     (P_DATA),
        .ser_bit  (ser_bit),
        .done     (ser_done)
    );

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statements can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Data_Valid) state_d = START;
            START:   state_d = DATA;
            DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered below.
        tx_d   = STOP_BIT;
        busy_d = 1'b1;
        case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   tx_d   = START_BIT;
            DATA:    tx_d   = ser_bit;
            PARITY:  tx_d   = par_bit_q;
            default: tx_d   = STOP_BIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_bit_q <= parity_bit(^P_DATA, PAR_TYP);
            end
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected frames are built from the frame
// format (start, LSB-first data, parity by popcount, stop) in a queue.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_q[$];

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt);
        int ones;
        ones = $countones(d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
        if (pe) exp_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
        exp_q.push_back(1'b1);
    endfunction

    // Called at a negedge: requests the frame, checks every bit and Busy,
    // scrambles the inputs mid-frame, and ends on the idle cycle after it.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input bit hold, input int inject_at);
        int n;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        build_frame(d, pe, pt);
        n = exp_q.size();
        @(negedge CLK);
        for (int i = 0; i < n; i++) begin
            check($sformatf("tx d=%02h pe=%0b pt=%0b bit%0d", d, pe, pt, i), TX_OUT, exp_q[i]);
            check($sformatf("busy d=%02h bit%0d", d, i), Busy, 1'b1);
            Data_Valid = hold || (i == inject_at);
            P_DATA     = (i == inject_at) ? 8'hFF : 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            @(negedge CLK);
        end
        check($sformatf("idle tx after %02h", d), TX_OUT, 1'b1);
        check($sformatf("idle busy after %02h", d), Busy, 1'b0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        Data_Valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check($sformatf("%s tx%0d", tag, i), TX_OUT, 1'b1);
            check($sformatf("%s busy%0d", tag, i), Busy, 1'b0);
        end
    endtask

    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("reset tx", TX_OUT, 1'b1);
        check("reset busy", Busy, 1'b0);
        RST = 1'b1;
        idle_cycles(2, "post-reset");

        // Directed frames from the test plan
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1);
        idle_cycles(2, "after A5 nopar");
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        idle_cycles(1, "after A5 even");
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1);
        idle_cycles(1, "after A5 odd");
        run_frame(8'h00, 1'b1, 1'b1, 1'b0, -1);
        idle_cycles(1, "after 00 odd");

        // Request during the frame (cycle 4) must be ignored
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3);
        idle_cycles(3, "after 3C ignore");

        // Data_Valid held high: back-to-back frames, one idle cycle apart
        for (int v = 0; v < 8; v++) begin
            logic [7:0] pv;
            pv = 8'h01 << v;
            run_frame(pv, 1'(v % 2), 1'(v / 2 % 2), 1'b1, -1);
        end
        idle_cycles(2, "after b2b");

        // Reset during data bit 3
        P_DATA     = 8'hC3;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        build_frame(8'hC3, 1'b1, 1'b0);
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("pre-reset tx bit%0d", i), TX_OUT, exp_q[i]);
            if (i < 4) @(negedge CLK);
        end
        #2 RST = 1'b0;
        #1;
        check("async reset tx", TX_OUT, 1'b1);
        check("async reset busy", Busy, 1'b0);
        @(negedge CLK);
        check("held reset tx", TX_OUT, 1'b1);
        RST = 1'b1;
        idle_cycles(12, "after mid-frame reset");
        run_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        idle_cycles(1, "after 55");

        // Randomized frames with occasional ignored requests
        for (int r = 0; r < 24; r++) begin
            logic [7:0] rd;
            logic       rpe, rpt;
            int         inj;
            rd  = 8'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
            run_frame(rd, rpe, rpt, 1'b0, inj);
            idle_cycles(int'($urandom_range(0, 2)), "random gap");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
